// File: rtl/noc_pkg.sv
// Shared packet geometry and field helpers for the PE-side NoC interface.
// Packet layout, LSB first: dest {x,y}, src {x,y}, payload.
package noc_pkg;

    localparam int X_SIZE      = 2;
    localparam int Y_SIZE      = 2;
    localparam int DATA_WIDTH  = 8;
    localparam int COORD_W     = X_SIZE + Y_SIZE;
    localparam int PKT_W       = 2 * COORD_W + DATA_WIDTH;

    localparam int DEST_LSB    = 0;
    localparam int SRC_LSB     = COORD_W;
    localparam int PAYLOAD_LSB = 2 * COORD_W;

    typedef logic [COORD_W-1:0]    coord_t;
    typedef logic [PKT_W-1:0]      pkt_t;
    typedef logic [DATA_WIDTH-1:0] payload_t;

    function automatic pkt_t pack_pkt(input payload_t payload, input coord_t src, input coord_t dest);
        return {payload, src, dest};
    endfunction

    function automatic coord_t pkt_dest(input pkt_t p);
        return p[DEST_LSB +: COORD_W];
    endfunction

    function automatic coord_t pkt_src(input pkt_t p);
        return p[SRC_LSB +: COORD_W];
    endfunction

    function automatic payload_t pkt_payload(input pkt_t p);
        return p[PAYLOAD_LSB +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on dout
// whenever empty is low. Push when full and pop when empty are ignored.
module noc_pkt_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/noc_pe_iface.sv
// PE-side network interface: fans one neuron result out to a fixed
// destination list and buffers packets addressed to this node.
//
// state   | meaning
// --------+----------------------------------------------------------
// TX_IDLE | waiting for a neuron result, o_nrn_ready high
// TX_SEND | presenting packet for DEST_LIST[tx_idx] until the switch takes it
module noc_pe_iface
    import noc_pkg::*;
#(
    parameter int x_size      = X_SIZE,
    parameter int y_size      = Y_SIZE,
    parameter int data_width  = DATA_WIDTH,
    parameter int total_width = 2*x_size + 2*y_size + data_width,
    parameter logic [x_size-1:0] x_coord = '0,
    parameter logic [y_size-1:0] y_coord = '0,
    parameter int NUM_DEST    = 3,
    parameter logic [NUM_DEST*(x_size+y_size)-1:0] DEST_LIST = '0,
    parameter int RX_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [data_width-1:0]  i_nrn_data,
    input  logic                   i_nrn_valid,
    output logic                   o_nrn_ready,
    output logic [total_width-1:0] o_data_sw,
    output logic                   o_valid_sw,
    input  logic                   i_ready_sw,
    input  logic [total_width-1:0] i_data_sw,
    input  logic                   i_valid_sw,
    output logic                   o_ready_sw,
    output logic [data_width-1:0]  o_rx_data,
    output logic [x_size-1:0]      o_rx_src_x,
    output logic [y_size-1:0]      o_rx_src_y,
    output logic                   o_rx_valid,
    input  logic                   i_rx_ready,
    output logic [7:0]             o_drop_cnt
);

    localparam int COORD_BITS = x_size + y_size;
    localparam int IDX_W      = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam int RX_W       = COORD_BITS + data_width;
    localparam int CNT_W      = $clog2(RX_DEPTH) + 1;
    localparam logic [COORD_BITS-1:0] SELF     = {x_coord, y_coord};
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DEST - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t             tx_state;
    logic [IDX_W-1:0]      tx_idx;
    logic [data_width-1:0] tx_payload;

    function automatic coord_t dest_at(input logic [IDX_W-1:0] i);
        return DEST_LIST[int'(i)*COORD_BITS +: COORD_BITS];
    endfunction

    // A reset mid-burst simply returns to idle; the rest of the fan-out is lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state    <= TX_IDLE;
            tx_idx      <= '0;
            o_valid_sw  <= 1'b0;
            o_nrn_ready <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (i_nrn_valid) begin
                        tx_payload  <= i_nrn_data;
                        tx_idx      <= '0;
                        o_data_sw   <= pack_pkt(i_nrn_data, SELF, dest_at('0));
                        o_valid_sw  <= 1'b1;
                        o_nrn_ready <= 1'b0;
                        tx_state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (i_ready_sw) begin
                        if (tx_idx == LAST_IDX) begin
                            o_valid_sw  <= 1'b0;
                            o_nrn_ready <= 1'b1;
                            tx_state    <= TX_IDLE;
                        end else begin
                            tx_idx    <= tx_idx + 1'b1;
                            o_data_sw <= pack_pkt(tx_payload, SELF, dest_at(tx_idx + 1'b1));
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic             rx_accept;
    logic             rx_addr_ok;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic [CNT_W-1:0] rx_count;
    logic [RX_W-1:0]  rx_head;

    assign o_ready_sw = (rx_count < CNT_W'(RX_DEPTH));
    assign rx_accept  = i_valid_sw & o_ready_sw;
    assign rx_addr_ok = (pkt_dest(i_data_sw) == SELF);
    assign rx_push    = rx_accept & rx_addr_ok & ~rx_full;
    assign o_rx_valid = ~rx_empty;
    assign rx_pop     = o_rx_valid & i_rx_ready;

    noc_pkt_fifo #(
        .WIDTH (RX_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_push),
        .din   ({pkt_src(i_data_sw), pkt_payload(i_data_sw)}),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign o_rx_data  = rx_head[data_width-1:0];
    assign o_rx_src_y = rx_head[data_width +: y_size];
    assign o_rx_src_x = rx_head[RX_W-1 -: x_size];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_drop_cnt <= '0;
        end else if (rx_accept && !rx_addr_ok && o_drop_cnt != 8'hFF) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_noc_pe_iface.sv
// Directed bench for noc_pe_iface at node (1,0) with fan-out (2,1),(2,0),(3,0).
module tb_noc_pe_iface;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  i_nrn_data;
    logic        i_nrn_valid;
    logic        o_nrn_ready;
    logic [15:0] o_data_sw;
    logic        o_valid_sw;
    logic        i_ready_sw;
    logic [15:0] i_data_sw;
    logic        i_valid_sw;
    logic        o_ready_sw;
    logic [7:0]  o_rx_data;
    logic [1:0]  o_rx_src_x;
    logic [1:0]  o_rx_src_y;
    logic        o_rx_valid;
    logic        i_rx_ready;
    logic [7:0]  o_drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    noc_pe_iface #(
        .x_coord   (2'd1),
        .y_coord   (2'd0),
        .NUM_DEST  (3),
        .DEST_LIST (12'hC89),
        .RX_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_nrn_data  (i_nrn_data),
        .i_nrn_valid (i_nrn_valid),
        .o_nrn_ready (o_nrn_ready),
        .o_data_sw   (o_data_sw),
        .o_valid_sw  (o_valid_sw),
        .i_ready_sw  (i_ready_sw),
        .i_data_sw   (i_data_sw),
        .i_valid_sw  (i_valid_sw),
        .o_ready_sw  (o_ready_sw),
        .o_rx_data   (o_rx_data),
        .o_rx_src_x  (o_rx_src_x),
        .o_rx_src_y  (o_rx_src_y),
        .o_rx_valid  (o_rx_valid),
        .i_rx_ready  (i_rx_ready),
        .o_drop_cnt  (o_drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [7:0] p, input logic [1:0] sx,
                                       input logic [1:0] sy, input logic [3:0] dst);
        return {p, sx, sy, dst};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        checks++; if (o_valid_sw !== 1'b0) begin errors++; $display("FAIL reset_valid_sw: got %b want 0", o_valid_sw); end
        checks++; if (o_nrn_ready !== 1'b1) begin errors++; $display("FAIL reset_nrn_ready: got %b want 1", o_nrn_ready); end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", o_rx_valid); end
        checks++; if (o_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", o_drop_cnt); end
        checks++; if (o_ready_sw !== 1'b1) begin errors++; $display("FAIL reset_ready_sw: got %b want 1", o_ready_sw); end
    endtask

    task automatic test_fanout();
        logic [15:0] exp_pkt [3];
        exp_pkt[0] = 16'hA549;
        exp_pkt[1] = 16'hA548;
        exp_pkt[2] = 16'hA54C;
        i_ready_sw  = 1'b1;
        i_nrn_data  = 8'hA5;
        i_nrn_valid = 1'b1;
        tick();
        i_nrn_valid = 1'b0;
        i_nrn_data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_valid_sw !== 1'b1 || o_data_sw !== exp_pkt[i]) begin errors++; $display("FAIL fanout_pkt%0d: got v=%b %h want v=1 %h", i, o_valid_sw, o_data_sw, exp_pkt[i]); end
            checks++; if (o_nrn_ready !== 1'b0) begin errors++; $display("FAIL fanout_busy%0d: got %b want 0", i, o_nrn_ready); end
            tick();
        end
        checks++; if (o_valid_sw !== 1'b0 || o_nrn_ready !== 1'b1) begin errors++; $display("FAIL fanout_done: got v=%b rdy=%b want v=0 rdy=1", o_valid_sw, o_nrn_ready); end
    endtask

    task automatic test_backpressure();
        i_ready_sw  = 1'b1;
        i_nrn_data  = 8'h3C;
        i_nrn_valid = 1'b1;
        tick();
        i_nrn_data = 8'h77;
        checks++; if (o_data_sw !== 16'h3C49) begin errors++; $display("FAIL bp_pkt0: got %h want 3c49", o_data_sw); end
        tick();
        i_ready_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_valid_sw !== 1'b1 || o_data_sw !== 16'h3C48) begin errors++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 3c48", i, o_valid_sw, o_data_sw); end
            checks++; if (o_nrn_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready%0d: got %b want 0", i, o_nrn_ready); end
            tick();
        end
        checks++; if (o_data_sw !== 16'h3C48) begin errors++; $display("FAIL bp_hold_end: got %h want 3c48", o_data_sw); end
        i_ready_sw = 1'b1;
        tick();
        checks++; if (o_valid_sw !== 1'b1 || o_data_sw !== 16'h3C4C) begin errors++; $display("FAIL bp_pkt2: got v=%b %h want v=1 3c4c", o_valid_sw, o_data_sw); end
        tick();
        checks++; if (o_valid_sw !== 1'b0 || o_nrn_ready !== 1'b1) begin errors++; $display("FAIL bp_done: got v=%b rdy=%b want v=0 rdy=1", o_valid_sw, o_nrn_ready); end
        tick();
        i_nrn_valid = 1'b0;
        checks++; if (o_valid_sw !== 1'b1 || o_data_sw !== 16'h7749) begin errors++; $display("FAIL bp_next_pkt0: got v=%b %h want v=1 7749", o_valid_sw, o_data_sw); end
        tick();
        checks++; if (o_data_sw !== 16'h7748) begin errors++; $display("FAIL bp_next_pkt1: got %h want 7748", o_data_sw); end
        tick();
        checks++; if (o_data_sw !== 16'h774C) begin errors++; $display("FAIL bp_next_pkt2: got %h want 774c", o_data_sw); end
        tick();
        checks++; if (o_valid_sw !== 1'b0) begin errors++; $display("FAIL bp_next_done: got %b want 0", o_valid_sw); end
    endtask

    task automatic test_rx_fill();
        i_rx_ready = 1'b0;
        i_valid_sw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data_sw = mk(8'(8'h11 * (i + 1)), 2'(3 - i), 2'(i), 4'h4);
            checks++; if (o_ready_sw !== 1'b1) begin errors++; $display("FAIL rx_fill_ready%0d: got %b want 1", i, o_ready_sw); end
            tick();
        end
        i_data_sw = mk(8'h55, 2'd3, 2'd0, 4'h4);
        checks++; if (o_ready_sw !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b want 0", o_ready_sw); end
        checks++; if (o_rx_valid !== 1'b1 || o_rx_data !== 8'h11 || o_rx_src_x !== 2'd3 || o_rx_src_y !== 2'd0) begin errors++; $display("FAIL rx_full_head: got v=%b %h (%0d,%0d) want v=1 11 (3,0)", o_rx_valid, o_rx_data, o_rx_src_x, o_rx_src_y); end
        tick();
        tick();
        checks++; if (o_ready_sw !== 1'b0 || o_rx_data !== 8'h11) begin errors++; $display("FAIL rx_full_hold: got rdy=%b %h want rdy=0 11", o_ready_sw, o_rx_data); end
        i_rx_ready = 1'b1;
        tick();
        i_rx_ready = 1'b0;
        checks++; if (o_ready_sw !== 1'b1 || o_rx_data !== 8'h22) begin errors++; $display("FAIL rx_after_pop: got rdy=%b %h want rdy=1 22", o_ready_sw, o_rx_data); end
        tick();
        i_valid_sw = 1'b0;
        checks++; if (o_ready_sw !== 1'b0) begin errors++; $display("FAIL rx_refull: got %b want 0", o_ready_sw); end
        i_rx_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (o_rx_valid !== 1'b1 || o_rx_data !== 8'(8'h11 * (i + 1)) || o_rx_src_x !== 2'(3 - i) || o_rx_src_y !== 2'(i)) begin errors++; $display("FAIL rx_pop%0d: got v=%b %h (%0d,%0d) want v=1 %h (%0d,%0d)", i, o_rx_valid, o_rx_data, o_rx_src_x, o_rx_src_y, 8'(8'h11 * (i + 1)), 2'(3 - i), 2'(i)); end
            tick();
        end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL rx_drained: got %b want 0", o_rx_valid); end
        tick();
        checks++; if (o_rx_valid !== 1'b0 || o_ready_sw !== 1'b1) begin errors++; $display("FAIL rx_empty_pop: got v=%b rdy=%b want v=0 rdy=1", o_rx_valid, o_ready_sw); end
        i_rx_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        i_rx_ready = 1'b0;
        i_valid_sw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data_sw = mk(8'(8'h61 + i), 2'd1, 2'd1, 4'h4);
            tick();
        end
        i_data_sw  = mk(8'h64, 2'd2, 2'd1, 4'h4);
        i_rx_ready = 1'b1;
        tick();
        i_valid_sw = 1'b0;
        i_rx_ready = 1'b0;
        checks++; if (o_ready_sw !== 1'b1 || o_rx_data !== 8'h62) begin errors++; $display("FAIL pp_count3: got rdy=%b %h want rdy=1 62", o_ready_sw, o_rx_data); end
        i_rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_rx_valid !== 1'b1 || o_rx_data !== 8'(8'h62 + i)) begin errors++; $display("FAIL pp_pop%0d: got v=%b %h want v=1 %h", i, o_rx_valid, o_rx_data, 8'(8'h62 + i)); end
            if (i == 2) begin
                checks++; if (o_rx_src_x !== 2'd2 || o_rx_src_y !== 2'd1) begin errors++; $display("FAIL pp_src: got (%0d,%0d) want (2,1)", o_rx_src_x, o_rx_src_y); end
            end
            tick();
        end
        i_rx_ready = 1'b0;
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", o_rx_valid); end
    endtask

    task automatic test_drop();
        i_data_sw  = mk(8'h99, 2'd0, 2'd0, 4'h3);
        i_valid_sw = 1'b1;
        tick();
        i_valid_sw = 1'b0;
        checks++; if (o_drop_cnt !== 8'd1 || o_rx_valid !== 1'b0) begin errors++; $display("FAIL drop_one: got cnt=%0d v=%b want cnt=1 v=0", o_drop_cnt, o_rx_valid); end
        i_valid_sw = 1'b1;
        repeat (253) tick();
        checks++; if (o_drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d want 254", o_drop_cnt); end
        tick();
        checks++; if (o_drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_255: got %0d want 255", o_drop_cnt); end
        repeat (46) tick();
        i_valid_sw = 1'b0;
        checks++; if (o_drop_cnt !== 8'd255 || o_rx_valid !== 1'b0) begin errors++; $display("FAIL drop_sat: got cnt=%0d v=%b want cnt=255 v=0", o_drop_cnt, o_rx_valid); end
    endtask

    task automatic test_mid_reset();
        i_valid_sw = 1'b1;
        i_data_sw  = mk(8'hAA, 2'd0, 2'd1, 4'h4);
        tick();
        i_data_sw  = mk(8'hBB, 2'd0, 2'd1, 4'h4);
        tick();
        i_valid_sw = 1'b0;
        checks++; if (o_rx_valid !== 1'b1 || o_rx_data !== 8'hAA) begin errors++; $display("FAIL mr_setup_rx: got v=%b %h want v=1 aa", o_rx_valid, o_rx_data); end
        i_ready_sw  = 1'b1;
        i_nrn_data  = 8'hC3;
        i_nrn_valid = 1'b1;
        tick();
        i_nrn_valid = 1'b0;
        checks++; if (o_valid_sw !== 1'b1 || o_data_sw !== 16'hC349) begin errors++; $display("FAIL mr_setup_tx: got v=%b %h want v=1 c349", o_valid_sw, o_data_sw); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (o_valid_sw !== 1'b0) begin errors++; $display("FAIL mr_valid_sw: got %b want 0", o_valid_sw); end
        checks++; if (o_nrn_ready !== 1'b1) begin errors++; $display("FAIL mr_nrn_ready: got %b want 1", o_nrn_ready); end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL mr_rx_valid: got %b want 0", o_rx_valid); end
        checks++; if (o_drop_cnt !== 8'd0) begin errors++; $display("FAIL mr_drop_cnt: got %0d want 0", o_drop_cnt); end
        checks++; if (o_ready_sw !== 1'b1) begin errors++; $display("FAIL mr_ready_sw: got %b want 1", o_ready_sw); end
        tick();
        checks++; if (o_valid_sw !== 1'b0) begin errors++; $display("FAIL mr_no_resume: got %b want 0", o_valid_sw); end
    endtask

    initial begin
        rstn        = 1'b0;
        i_nrn_data  = '0;
        i_nrn_valid = 1'b0;
        i_ready_sw  = 1'b0;
        i_data_sw   = '0;
        i_valid_sw  = 1'b0;
        i_rx_ready  = 1'b0;
        test_reset();
        test_fanout();
        test_backpressure();
        test_rx_fill();
        test_push_pop();
        test_drop();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
